// File: rtl/his_builder_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : his_builder_stream_if
//  Description : Readout stream bundle of the histogram builder. It carries
//                one bin per handshake as valid/ready, with the bin index,
//                its count and a last-bin marker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface his_builder_stream_if #(
    parameter int BIN_W = 6,
    parameter int CNT_W = 21
);
    logic             rd_valid;
    logic             rd_ready;
    logic [BIN_W-1:0] rd_bin;
    logic [CNT_W-1:0] rd_count;
    logic             rd_last;

    // The histogram builder sources the stream.
    modport master (
        output rd_valid,
        output rd_bin,
        output rd_count,
        output rd_last,
        input  rd_ready
    );

    // The downstream processing stage sinks the stream.
    modport slave (
        input  rd_valid,
        input  rd_bin,
        input  rd_count,
        input  rd_last,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/his_builder_stream.sv
`default_nettype none
// ============================================================================
//  Module      : his_builder_stream
//  Description : Single-pixel dToF histogram builder. It counts TDC bin hits
//                over ACQ_NUM laser cycles, then streams every bin out in
//                index order on a valid/ready port, clearing each bin as it
//                is read. Bins are cleared lazily through per-bin valid
//                bits, so no clear sweep is needed between frames.
//  Options     : define PEAK_DETECT_EN to track the highest bin of each
//                drained frame on peak_bin/peak_count (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module his_builder_stream #(
    parameter int BIN_W   = 6,
    parameter int CNT_W   = 21,
    parameter int ACQ_NUM = 1024,
    parameter int ACQ_W   = 17
) (
    input  wire              clk,
    input  wire              res,
    input  wire              cycle_end,
    input  wire              ts_valid,
    input  wire  [BIN_W-1:0] ts_bin,
    output logic             ts_drop,
    his_builder_stream_if.master rd,
    output logic             frame_done,
    output logic             sat_flag,
    output logic [BIN_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count
);

    localparam int               c_NUM_BINS = 2 ** BIN_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [BIN_W-1:0] c_BIN_LAST = '1;
    localparam logic [ACQ_W-1:0] c_ACQ_LAST = ACQ_W'(ACQ_NUM - 1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACQ_W-1:0] r_acq_cnt;
    logic [BIN_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] r_bins [c_NUM_BINS];
    logic [c_NUM_BINS-1:0] r_bin_vld;
    logic             r_ts_drop;
    logic             r_frame_done;
    logic             r_sat;

    logic             w_hit;
    logic             w_acq_wrap;
    logic             w_rd_valid;
    logic             w_hs;
    logic             w_hs_last;
    logic [CNT_W-1:0] w_hit_cur;
    logic [CNT_W-1:0] w_hit_new;
    logic [CNT_W-1:0] w_rd_cur;

    // A bin whose valid bit is clear reads as zero: this is the lazy clear.
    assign w_hit_cur = r_bin_vld[ts_bin]   ? r_bins[ts_bin]   : '0;
    assign w_rd_cur  = r_bin_vld[r_rd_idx] ? r_bins[r_rd_idx] : '0;
    assign w_hit_new = (w_hit_cur == c_CNT_MAX) ? w_hit_cur : w_hit_cur + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= S_ACCUM;
        else     r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_acq_wrap  = 1'b0;
        w_rd_valid  = 1'b0;
        w_hs        = 1'b0;
        w_hs_last   = 1'b0;
        case (r_state)
            S_ACCUM: begin
                w_hit = ts_valid;
                if (cycle_end && (r_acq_cnt == c_ACQ_LAST)) begin
                    w_acq_wrap  = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_rd_valid = 1'b1;
                w_hs       = rd.rd_ready;
                if (rd.rd_ready && (r_rd_idx == c_BIN_LAST)) begin
                    w_hs_last   = 1'b1;
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    // Laser-cycle counter; it only advances while accumulating.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_acq_cnt <= '0;
        end else if ((r_state == S_ACCUM) && cycle_end) begin
            r_acq_cnt <= w_acq_wrap ? '0 : r_acq_cnt + ACQ_W'(1);
        end
    end

    // Bin counters: no reset needed since the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (w_hit) r_bins[ts_bin] <= w_hit_new;
    end

    // Valid bits: set by a hit, cleared when the bin is handed downstream.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_bin_vld <= '0;
        end else if (w_hit) begin
            r_bin_vld[ts_bin] <= 1'b1;
        end else if (w_hs) begin
            r_bin_vld[r_rd_idx] <= 1'b0;
        end
    end

    // Readout index; wraps back to 0 after the last bin is accepted.
    always_ff @(posedge clk or posedge res) begin
        if (res)       r_rd_idx <= '0;
        else if (w_hs) r_rd_idx <= r_rd_idx + BIN_W'(1);
    end

    // Status pulses and the per-frame saturation flag.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_ts_drop    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_ts_drop    <= ts_valid && (r_state == S_DRAIN);
            r_frame_done <= w_hs_last;
            if (w_hs_last)
                r_sat <= 1'b0;
            else if (w_hit && (w_hit_new == c_CNT_MAX))
                r_sat <= 1'b1;
        end
    end

    assign ts_drop     = r_ts_drop;
    assign frame_done  = r_frame_done;
    assign sat_flag    = r_sat;
    assign rd.rd_valid = w_rd_valid;
    assign rd.rd_bin   = r_rd_idx;
    assign rd.rd_count = w_rd_valid ? w_rd_cur : '0;
    assign rd.rd_last  = w_rd_valid && (r_rd_idx == c_BIN_LAST);

`ifdef PEAK_DETECT_EN
    logic [BIN_W-1:0] r_run_bin;
    logic [CNT_W-1:0] r_run_cnt;
    logic [BIN_W-1:0] r_peak_bin;
    logic [CNT_W-1:0] r_peak_cnt;
    logic             w_take;

    // Bin 0 always seeds the running max; later bins replace it only when
    // strictly greater, so ties keep the lowest index.
    assign w_take = (r_rd_idx == '0) || (w_rd_cur > r_run_cnt);

    // Running max during drain, published when the last bin is accepted.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_run_bin  <= '0;
            r_run_cnt  <= '0;
            r_peak_bin <= '0;
            r_peak_cnt <= '0;
        end else if (w_hs) begin
            if (w_take) begin
                r_run_bin <= r_rd_idx;
                r_run_cnt <= w_rd_cur;
            end
            if (w_hs_last) begin
                r_peak_bin <= w_take ? r_rd_idx : r_run_bin;
                r_peak_cnt <= w_take ? w_rd_cur : r_run_cnt;
            end
        end
    end

    assign peak_bin   = r_peak_bin;
    assign peak_count = r_peak_cnt;
`else
    assign peak_bin   = '0;
    assign peak_count = '0;
`endif

endmodule
`default_nettype wire
